// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: session controller for serial pattern detection.
//
// A job (pattern, length, overlap mode, bit budget) is latched on a start
// pulse in IDLE. In RUN the block pulls serial bits over a valid/ready
// handshake, shifts them into a history register and flags every match with a
// registered one-cycle det pulse. Matches are counted (saturating). The job
// ends in DONE (one cycle) after num_bits accepted bits, after TIMEOUT idle
// cycles, or right away for an invalid job. In the last two cases err is set.
//
// Handshake: a bit is transferred on a rising clk edge where
//   bit_valid & bit_ready. bit_ready is high throughout RUN and depends only
//   on state, never on bit_valid. The source must hold bit_in stable while
//   bit_valid is high and not yet accepted.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      job request, sampled only in IDLE
//   pat        pattern; pat[0] = most recent bit, pat[pat_len-1] = oldest
//   pat_len    pattern length, valid 1..MAX_LEN
//   overlap    1 = matches may share bits
//   num_bits   number of serial bits to consume
//   bit_valid  serial source offers bit_in
//   bit_in     serial data bit
//   bit_ready  controller accepts a bit this cycle (RUN)
//   busy       high in RUN and DONE
//   det        one-cycle match pulse, cycle after the completing bit
//   done       one-cycle job-complete pulse (state DONE)
//   err        sticky job error, cleared at the next accepted start
//   match_cnt  saturating match counter for the current/last job
//   state_dbg  current FSM state for observation
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [4:0]         pat_len,
  input  logic               overlap,
  input  logic [CNT_W-1:0]   num_bits,
  input  logic               bit_valid,
  input  logic               bit_in,
  output logic               bit_ready,
  output logic               busy,
  output logic               det,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int FILL_W = $clog2(MAX_LEN + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [1:0]         state;
  logic [MAX_LEN-1:0] pat_q;
  logic [4:0]         len_q;
  logic               ov_q;
  logic [CNT_W-1:0]   nb_q;
  logic [MAX_LEN-1:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [CNT_W-1:0]   consumed;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               det_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] mask;
  logic [FILL_W-1:0]  fill_sat;
  logic [5:0]         fill_ext;
  logic               hit;
  logic               last_bit;
  logic               timeout_hit;
  logic               bad_job;

  always_comb begin
    hist_nxt = {hist[MAX_LEN-2:0], bit_in};
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (5'(i) < len_q);
    end
    // fill counts history bits usable by the next match; a match needs
    // pat_len of them including the bit being accepted.
    fill_ext    = 6'(fill) + 6'd1;
    hit         = (fill_ext >= {1'b0, len_q}) &&
                  ((hist_nxt & mask) == (pat_q & mask));
    fill_sat    = (fill == FILL_W'(MAX_LEN)) ? fill : fill + FILL_W'(1);
    last_bit    = ((consumed + CNT_W'(1)) == nb_q);
    timeout_hit = (idle_cnt == IDLE_W'(TIMEOUT - 1));
    bad_job     = (pat_len == 5'd0) || (pat_len > 5'(MAX_LEN)) ||
                  (num_bits == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      ov_q     <= 1'b0;
      nb_q     <= '0;
      hist     <= '0;
      fill     <= '0;
      consumed <= '0;
      idle_cnt <= '0;
      det_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      det_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pat_q    <= pat;
            len_q    <= pat_len;
            ov_q     <= overlap;
            nb_q     <= num_bits;
            hist     <= '0;
            fill     <= '0;
            consumed <= '0;
            idle_cnt <= '0;
            cnt_q    <= '0;
            err_q    <= bad_job;
            state    <= bad_job ? DONE : RUN;
          end
        end
        RUN: begin
          if (bit_valid) begin
            hist     <= hist_nxt;
            consumed <= consumed + CNT_W'(1);
            idle_cnt <= '0;
            if (hit) begin
              det_q <= 1'b1;
              if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
              // Without overlap, restart filling so no bit is reused.
              fill <= ov_q ? fill_sat : '0;
            end else begin
              fill <= fill_sat;
            end
            if (last_bit) state <= DONE;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bit_ready = (state == RUN);
  assign busy      = (state == RUN) || (state == DONE);
  assign done      = (state == DONE);
  assign det       = det_q;
  assign err       = err_q;
  assign match_cnt = cnt_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Testbench for seq_detect_ctrl: table of directed jobs with hand-computed
// det patterns and results, plus hand-written timeout, mid-job reset and
// randomly-gapped sequences. Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pat;
  logic [4:0] pat_len;
  logic       overlap;
  logic [7:0] num_bits;
  logic       bit_valid;
  logic       bit_in;
  logic       bit_ready;
  logic       busy;
  logic       det;
  logic       done;
  logic       err;
  logic [7:0] match_cnt;
  logic [1:0] state_dbg;

  int total = 0;
  int bad   = 0;

  // Expected det value for each accepted bit, consumed in order.
  logic [0:0] exp_q[$];

  typedef struct {
    logic [7:0]  pat;
    logic [4:0]  len;
    logic        ov;
    logic [7:0]  nb;
    logic [15:0] stream;   // bit i = i-th bit sent in time
    logic [15:0] exp_det;  // bit i = det expected after i-th bit
    logic [7:0]  exp_cnt;
    logic        exp_err;  // invalid job: DONE right after start
  } vec_t;

  vec_t vecs[11];

  seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .start(start), .pat(pat), .pat_len(pat_len),
    .overlap(overlap), .num_bits(num_bits), .bit_valid(bit_valid),
    .bit_in(bit_in), .bit_ready(bit_ready), .busy(busy), .det(det),
    .done(done), .err(err), .match_cnt(match_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_ready"}, bit_ready, 0);
    chk({name, "_busy"},  busy, 0);
    chk({name, "_det"},   det, 0);
    chk({name, "_done"},  done, 0);
  endtask

  // Run one job. gaps=1 inserts random bit_valid=0 cycles and stray start
  // pulses while in RUN; results must be the same as with no gaps.
  task automatic run_job(input vec_t v, input bit gaps, input string name);
    @(negedge clk);
    start = 1'b1; pat = v.pat; pat_len = v.len; overlap = v.ov;
    num_bits = v.nb;
    @(negedge clk);
    start = 1'b0;
    if (v.exp_err) begin
      chk({name, "_done"},  done, 1);
      chk({name, "_ready"}, bit_ready, 0);
      chk({name, "_err"},   err, 1);
      chk({name, "_cnt"},   match_cnt, 0);
      @(negedge clk);
      chk({name, "_ready2"}, bit_ready, 0);
      chk({name, "_done2"},  done, 0);
      chk({name, "_err2"},   err, 1);
      return;
    end
    for (int i = 0; i < int'(v.nb); i++) exp_q.push_back(v.exp_det[i]);
    chk({name, "_ready"}, bit_ready, 1);
    for (int i = 0; i < int'(v.nb); i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin
          bit_valid = 1'b0;
          start = 1'($urandom_range(0, 1));
          pat = 8'hFF; pat_len = 5'd1; num_bits = 8'd1;
          @(negedge clk);
          start = 1'b0;
        end
      end
      bit_valid = 1'b1;
      bit_in = v.stream[i];
      @(negedge clk);
      bit_valid = 1'b0;
      chk($sformatf("%s_det%0d", name, i), det, exp_q.pop_front());
    end
    chk({name, "_done"}, done, 1);
    chk({name, "_busy"}, busy, 1);
    chk({name, "_cnt"},  match_cnt, v.exp_cnt);
    chk({name, "_err"},  err, 0);
    @(negedge clk);
    chk({name, "_done_off"}, done, 0);
    chk({name, "_busy_off"}, busy, 0);
    chk({name, "_cnt_hold"}, match_cnt, v.exp_cnt);
  endtask

  // ---------------- main ----------------
  initial begin
    int cyc;

    //            pat    len  ov nb     stream     exp_det   cnt  err
    vecs[0]  = '{8'h01, 5'd3, 0, 8'd6, 16'h0024, 16'h0024, 8'd2, 0};
    vecs[1]  = '{8'h05, 5'd4, 1, 8'd6, 16'h002A, 16'h0028, 8'd2, 0};
    vecs[2]  = '{8'h05, 5'd4, 0, 8'd6, 16'h002A, 16'h0008, 8'd1, 0};
    vecs[3]  = '{8'h01, 5'd1, 0, 8'd4, 16'h000D, 16'h000D, 8'd3, 0};
    vecs[4]  = '{8'hA5, 5'd8, 1, 8'd9, 16'h00A5, 16'h0080, 8'd1, 0};
    vecs[5]  = '{8'hF1, 5'd3, 1, 8'd6, 16'h0024, 16'h0024, 8'd2, 0};
    vecs[6]  = '{8'h03, 5'd2, 1, 8'd4, 16'h000F, 16'h000E, 8'd3, 0};
    vecs[7]  = '{8'h03, 5'd2, 0, 8'd4, 16'h000F, 16'h000A, 8'd2, 0};
    vecs[8]  = '{8'h01, 5'd0, 0, 8'd6, 16'h0000, 16'h0000, 8'd0, 1};
    vecs[9]  = '{8'h01, 5'd9, 0, 8'd6, 16'h0000, 16'h0000, 8'd0, 1};
    vecs[10] = '{8'h01, 5'd3, 0, 8'd0, 16'h0000, 16'h0000, 8'd0, 1};

    rst = 1'b0; start = 1'b0; pat = '0; pat_len = '0; overlap = 1'b0;
    num_bits = '0; bit_valid = 1'b0; bit_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_err", err, 0);
    chk("reset_cnt", match_cnt, 0);
    chk("reset_state", state_dbg, 0);
    rst = 1'b1;

    for (int j = 0; j < 11; j++) run_job(vecs[j], 1'b0, $sformatf("vec%0d", j));

    // Error from the previous invalid job clears on the next good start.
    run_job(vecs[0], 1'b0, "err_clear");

    // Idle timeout: valid job, no bits offered.
    @(negedge clk);
    start = 1'b1; pat = 8'h01; pat_len = 5'd3; overlap = 1'b0; num_bits = 8'd6;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("timeout_cycles", cyc, 255);
    chk("timeout_done", done, 1);
    chk("timeout_err", err, 1);
    chk("timeout_cnt", match_cnt, 0);
    @(negedge clk);
    chk("timeout_idle", busy, 0);

    // Reset in the middle of a job, right after a match.
    @(negedge clk);
    start = 1'b1; pat = 8'h01; pat_len = 5'd3; overlap = 1'b0; num_bits = 8'd6;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; bit_in = (i == 2);
      @(negedge clk);
    end
    bit_valid = 1'b0;
    chk("prerst_det", det, 1);
    chk("prerst_cnt", match_cnt, 1);
    #1 rst = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    chk("midrst_cnt", match_cnt, 0);
    chk("midrst_err", err, 0);
    cyc = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) cyc++;
    end
    chk("midrst_no_done", cyc, 0);
    rst = 1'b1;
    run_job(vecs[0], 1'b0, "after_rst");

    // Randomly gapped bit_valid with stray start pulses during RUN.
    run_job(vecs[0], 1'b1, "gap1");
    run_job(vecs[1], 1'b1, "gap2");
    run_job(vecs[7], 1'b1, "gap3");

    chk("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
